// File: rtl/fpu_mul_seq_pkg.sv
// Shared constants, fflags bit positions and FSM encoding for the sequential FP multiplier.
package fpu_mul_seq_pkg;

  localparam logic [4:0]  FPU_SEL_MUL = 5'd6;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam int          FP_BIAS     = 127;

  // fflags = {NV, DZ, OF, UF, NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StNorm,
    StDone
  } state_e;

endpackage

// File: rtl/fpu_round_rne.sv
// Combinational normalise + round-to-nearest-even of a 48-bit mantissa product.
// The product's leading one may sit in bit 47 or bit 46; OF saturates to inf, UF flushes to zero.
module fpu_round_rne (
  input  logic [47:0]        prod_i,
  input  logic signed [9:0]  exp_i,
  output logic [30:0]        mag_o,
  output logic               of_o,
  output logic               uf_o,
  output logic               nx_o
);

  logic [46:0]       norm;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic              rnd_up;

  // Normalise, round, then classify the final exponent.
  always_comb begin
    norm   = prod_i[47] ? {prod_i[47:2], prod_i[1] | prod_i[0]} : prod_i[46:0];
    exp_n  = exp_i + (prod_i[47] ? 10'sd1 : 10'sd0);
    mant   = norm[46:23];
    guard  = norm[22];
    sticky = |norm[21:0];
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, rnd_up};
    // Carry-out means the mantissa rolled over to 1.0 of the next binade.
    exp_r  = exp_n + (mant_r[24] ? 10'sd1 : 10'sd0);
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    of_o   = exp_r >= 10'sd255;
    uf_o   = exp_r <= 10'sd0;
    nx_o   = of_o | uf_o | guard | sticky;
    if (of_o) begin
      mag_o = {8'hFF, 23'd0};
    end else if (uf_o) begin
      mag_o = 31'd0;
    end else begin
      mag_o = {exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/fpu_mul_seq.sv
// Sequential binary32 multiplier (FMUL.S): shift-add mantissa product, RNE rounding, fflags.
module fpu_mul_seq
  import fpu_mul_seq_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [4:0]  sel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o
);

  localparam int unsigned N = 24 / BITS_PER_CYCLE;

  state_e            state_q;
  logic              sign_q;
  logic signed [9:0] e_q;
  logic [47:0]       ma_q;
  logic [23:0]       mb_q;
  logic [47:0]       acc_q;
  logic [47:0]       acc_d;
  logic [4:0]        cnt_q;
  logic [31:0]       result_q;
  logic [4:0]        fflags_q;

  logic        accept;
  logic [7:0]  ea, eb;
  logic        za, zb, infa, infb, nana, nanb, snana, snanb, special;
  logic [31:0] spec_res;
  logic [4:0]  spec_flags;
  logic [30:0] rnd_mag;
  logic        rnd_of, rnd_uf, rnd_nx;

  assign accept = (state_q == StIdle) && valid_i && (sel_i == FPU_SEL_MUL) && !flush_i;

  // Operand classification and special-case result; denormals count as zero.
  always_comb begin
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    za    = (ea == 8'd0);
    zb    = (eb == 8'd0);
    infa  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    infb  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
    nana  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    nanb  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    snana = nana && !a_i[22];
    snanb = nanb && !b_i[22];
    special    = za || zb || (ea == 8'hFF) || (eb == 8'hFF);
    spec_flags = 5'd0;
    if (nana || nanb) begin
      spec_res            = FP_QNAN;
      spec_flags[FLAG_NV] = snana || snanb;
    end else if ((infa && zb) || (za && infb)) begin
      spec_res            = FP_QNAN;
      spec_flags[FLAG_NV] = 1'b1;
    end else if (infa || infb) begin
      spec_res = {a_i[31] ^ b_i[31], 8'hFF, 23'd0};
    end else begin
      spec_res = {a_i[31] ^ b_i[31], 31'd0};
    end
  end

  // Retire BITS_PER_CYCLE multiplier bits into the accumulator.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      if (mb_q[k]) acc_d = acc_d + (ma_q << k);
    end
  end

  fpu_round_rne u_round (
    .prod_i (acc_q),
    .exp_i  (e_q),
    .mag_o  (rnd_mag),
    .of_o   (rnd_of),
    .uf_o   (rnd_uf),
    .nx_o   (rnd_nx)
  );

  // FSM and datapath; flush aborts without touching the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      e_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sign_q <= a_i[31] ^ b_i[31];
            e_q    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(FP_BIAS);
            ma_q   <= {24'd0, 1'b1, a_i[22:0]};
            mb_q   <= {1'b1, b_i[22:0]};
            acc_q  <= '0;
            cnt_q  <= '0;
            if (special) begin
              result_q <= spec_res;
              fflags_q <= spec_flags;
              state_q  <= StDone;
            end else begin
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          acc_q <= acc_d;
          ma_q  <= ma_q << BITS_PER_CYCLE;
          mb_q  <= mb_q >> BITS_PER_CYCLE;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(N - 1)) state_q <= StNorm;
        end
        StNorm: begin
          result_q <= {sign_q, rnd_mag};
          fflags_q <= {1'b0, 1'b0, rnd_of, rnd_uf, rnd_nx};
          state_q  <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o  = !flush_i && (accept || state_q == StMul || state_q == StNorm);
  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed self-checking bench for fpu_mul_seq (BITS_PER_CYCLE = 1).
module tb_fpu_mul_seq;

  localparam int NORM_DONE = 26;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [4:0]  sel = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  fflags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_mul_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid),
    .sel_i    (sel),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .fflags_o (fflags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_tests++; if (fflags !== 5'd0) begin n_fail++; $display("FAIL reset_fflags: got %b want 0", fflags); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst_n = 1'b1;
    step();
  endtask

  // Issue one multiply and check done timing, stall profile, result and flags.
  task automatic test_mul(input string name, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp_r, input logic [4:0] exp_f, input int exp_cyc);
    int done_cyc;
    int stall_bad;
    logic [31:0] got_r;
    logic [4:0]  got_f;
    a = aa; b = bb; sel = 5'd6; valid = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall0: got %b want 1", name, stall); end
    done_cyc = -1; stall_bad = 0; got_r = 'x; got_f = 'x;
    for (int c = 1; c <= 40; c++) begin
      step();
      valid = 1'b0;
      #1;
      if (stall !== (c < exp_cyc)) stall_bad++;
      if (done === 1'b1) begin
        done_cyc = c; got_r = result; got_f = fflags;
        break;
      end
    end
    n_tests++;
    if (done_cyc != exp_cyc) begin n_fail++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, exp_cyc); end
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, got_r, exp_r); end
    n_tests++;
    if (got_f !== exp_f) begin n_fail++; $display("FAIL %s_fflags: got %b want %b", name, got_f, exp_f); end
    n_tests++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL %s_stall_profile: got %0d bad cycles want 0", name, stall_bad); end
    step();
  endtask

  task automatic test_non_mul();
    logic [4:0] sels [3] = '{5'd4, 5'd7, 5'd12};
    for (int i = 0; i < 3; i++) begin
      a = 32'h3FC00000; b = 32'h40000000; sel = sels[i]; valid = 1'b1;
      #1;
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL non_mul_stall sel=%0d: got %b want 0", sels[i], stall); end
      step();
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL non_mul_busy sel=%0d: got %b want 0", sels[i], busy); end
    end
    valid = 1'b0; sel = 5'd0;
  endtask

  // Abort at cycle 10 via flush (use_reset=0) or reset (use_reset=1).
  task automatic test_abort(input bit use_reset, input logic [31:0] prev_r, input logic [4:0] prev_f);
    int seen_done;
    string nm;
    nm = use_reset ? "reset_midop" : "flush";
    a = 32'h3FC00000; b = 32'h40000000; sel = 5'd6; valid = 1'b1;
    seen_done = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      valid = 1'b0;
      if (done === 1'b1) seen_done++;
    end
    if (use_reset) rst_n = 1'b0;
    else flush = 1'b1;
    #1;
    if (!use_reset) begin
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
    end
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", nm, busy); end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall_after: got %b want 0", nm, stall); end
    flush = 1'b0; rst_n = 1'b1;
    for (int c = 12; c <= 40; c++) begin
      step();
      if (done === 1'b1) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin n_fail++; $display("FAIL %s_no_done: got %0d strobes want 0", nm, seen_done); end
    n_tests++;
    if (result !== prev_r) begin n_fail++; $display("FAIL %s_result: got %h want %h", nm, result, prev_r); end
    n_tests++;
    if (fflags !== prev_f) begin n_fail++; $display("FAIL %s_fflags: got %b want %b", nm, fflags, prev_f); end
  endtask

  // Instruction held valid: second multiply may only be accepted the cycle after DONE.
  task automatic test_back_to_back();
    int first_done, second_done;
    a = 32'h3FC00000; b = 32'h40000000; sel = 5'd6; valid = 1'b1;
    first_done = -1; second_done = -1;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 28) valid = 1'b0;
      #1;
      if (done === 1'b1 && first_done < 0) first_done = c;
      else if (done === 1'b1 && second_done < 0) second_done = c;
      if (c == 26) begin
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_done: got %b want 0", stall); end
        a = 32'h40000000; b = 32'h40400000;
      end
      if (c == 27) begin
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_idle: got %b want 0", busy); end
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_accept: got %b want 1", stall); end
      end
      if (second_done > 0) break;
    end
    n_tests++;
    if (first_done != 26) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 26", first_done); end
    n_tests++;
    if (second_done != 53) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 53", second_done); end
    n_tests++;
    if (result !== 32'h40C00000) begin n_fail++; $display("FAIL b2b_result: got %h want 40c00000", result); end
    valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mul("nominal",   32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, NORM_DONE);
    test_mul("round_nx",  32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, NORM_DONE);
    test_mul("round_tie", 32'h3F800800, 32'h3F800800, 32'h3F801000, 5'b00001, NORM_DONE);
    test_mul("round_up",  32'h3F800801, 32'h3F800801, 32'h3F801003, 5'b00001, NORM_DONE);
    test_mul("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00101, NORM_DONE);
    test_mul("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, NORM_DONE);
    test_mul("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    test_mul("snan",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    test_mul("neg_zero",  32'hBF800000, 32'h00000000, 32'h80000000, 5'b00000, 1);
    test_non_mul();
    test_abort(1'b0, 32'h80000000, 5'b00000);
    test_abort(1'b1, 32'h00000000, 5'b00000);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
